// File: rtl/adc_capture_engine.sv
// adc_capture_engine: triggered ring-buffer ADC capture
// with programmable pre-trigger length and ordered readback.
module adc_capture_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  adc_clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [1:0]            trig_mode,
  input  logic                  trig_in,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic [ADDR_WIDTH-1:0] pretrig_len,
  output logic                  busy,
  output logic                  triggered,
  output logic                  capture_done,
  output logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] ALL1 = '1;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } state_t;

  state_t state;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic [ADDR_WIDTH-1:0] plen_q;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] thr_q;
  logic [DATA_WIDTH-1:0] prev;
  logic                  prev_ok;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  wr_en;
  logic                  trig_hit;
  logic                  pre_last;
  logic                  lvl_rise;
  logic                  lvl_fall;
  logic [ADDR_WIDTH-1:0] rd_phys;

  // Write strobe, trigger detect and logical-to-physical read map
  always_comb begin
    wr_en    = 1'b0;
    trig_hit = 1'b0;
    if (reset_n && !abort) begin
      wr_en = (state == PRE) ||
              (state == WAIT_TRIG) ||
              (state == POST);
    end
    pre_last = (wr_ptr == (plen_q - ONE));
    lvl_rise = prev_ok &&
               (prev < thr_q) &&
               (adc_data >= thr_q);
    lvl_fall = prev_ok &&
               (prev > thr_q) &&
               (adc_data <= thr_q);
    unique case (mode_q)
      2'd0: trig_hit = trig_in;
      2'd1: trig_hit = lvl_rise;
      2'd2: trig_hit = lvl_fall;
      2'd3: trig_hit = 1'b0;
    endcase
    rd_phys = start_addr + read_addr;
  end

  // Capture sequencer with registered status outputs
  always_ff @(posedge adc_clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      triggered    <= 1'b0;
      capture_done <= 1'b0;
      start_addr   <= '0;
      wr_ptr       <= '0;
      post_cnt     <= '0;
      plen_q       <= '0;
      mode_q       <= '0;
      thr_q        <= '0;
      prev         <= '0;
      prev_ok      <= 1'b0;
    end else if (abort) begin
      state        <= IDLE;
      busy         <= 1'b0;
      triggered    <= 1'b0;
      capture_done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            mode_q       <= trig_mode;
            thr_q        <= threshold;
            plen_q       <= pretrig_len;
            triggered    <= 1'b0;
            capture_done <= 1'b0;
            busy         <= 1'b1;
            wr_ptr       <= '0;
            prev_ok      <= 1'b0;
            if (pretrig_len != '0) begin
              state <= PRE;
            end else begin
              state <= WAIT_TRIG;
            end
          end
        end
        PRE: begin
          wr_ptr  <= wr_ptr + ONE;
          prev    <= adc_data;
          prev_ok <= 1'b1;
          if (pre_last) begin
            state <= WAIT_TRIG;
          end
        end
        WAIT_TRIG: begin
          wr_ptr  <= wr_ptr + ONE;
          prev    <= adc_data;
          prev_ok <= 1'b1;
          if (trig_hit) begin
            triggered  <= 1'b1;
            start_addr <= wr_ptr - plen_q;
            // DEPTH - P - 1 in natural wrap is ~P
            post_cnt   <= ~plen_q;
            if (plen_q == ALL1) begin
              state        <= DONE;
              busy         <= 1'b0;
              capture_done <= 1'b1;
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          wr_ptr   <= wr_ptr + ONE;
          post_cnt <= post_cnt - ONE;
          if (post_cnt == ONE) begin
            state        <= DONE;
            busy         <= 1'b0;
            capture_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sample RAM write port (contents survive reset)
  always_ff @(posedge adc_clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= adc_data;
    end
  end

  // Registered read port in record order
  always_ff @(posedge adc_clock) begin
    if (!reset_n) begin
      read_data <= '0;
    end else begin
      read_data <= mem[rd_phys];
    end
  end

endmodule

// File: tb/tb_adc_capture_engine.sv
// tb_adc_capture_engine: directed scenarios, scoreboard
// on the read port plus direct status checks.
module tb_adc_capture_engine;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          adc_clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    trig_mode = '0;
  logic          trig_in = 1'b0;
  logic [DW-1:0] threshold = '0;
  logic [AW-1:0] pretrig_len = '0;
  logic          busy;
  logic          triggered;
  logic          capture_done;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] read_addr = '0;
  logic [DW-1:0] read_data;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;
  logic          rd_req = 1'b0;
  logic          rd_v = 1'b0;

  adc_capture_engine #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .adc_clock   (adc_clock),
    .reset_n     (reset_n),
    .adc_data    (adc_data),
    .arm         (arm),
    .abort       (abort),
    .trig_mode   (trig_mode),
    .trig_in     (trig_in),
    .threshold   (threshold),
    .pretrig_len (pretrig_len),
    .busy        (busy),
    .triggered   (triggered),
    .capture_done(capture_done),
    .start_addr  (start_addr),
    .read_addr   (read_addr),
    .read_data   (read_data)
  );

  always #5 adc_clock = ~adc_clock;

  always @(posedge adc_clock) rd_v <= rd_req;

  // read-port monitor: one result per issued read
  always @(negedge adc_clock) begin
    if (rd_v) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: got %0h with no expected value",
                 read_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (read_data !== exp_v) begin
          fails++;
          $display("FAIL rd_data: got %0h expected %0h",
                   read_data, exp_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic [DW-1:0] d);
    adc_data = d;
    @(posedge adc_clock);
    #1;
  endtask

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic rd(input int idx, input logic [DW-1:0] e);
    read_addr = AW'(idx);
    rd_req = 1'b1;
    exp_q.push_back(e);
    tick(8'h00);
  endtask

  task automatic rd_end();
    rd_req = 1'b0;
    tick(8'h00);
    tick(8'h00);
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [DW-1:0] th,
                        input logic [AW-1:0] p);
    trig_mode = m;
    threshold = th;
    pretrig_len = p;
    arm = 1'b1;
    tick(8'hEE);
    arm = 1'b0;
  endtask

  initial begin
    // reset state
    tick(8'h00);
    tick(8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_trig", triggered, 0);
    chk("rst_done", capture_done, 0);
    chk("rst_start", start_addr, 0);
    chk("rst_rdata", read_data, 0);
    reset_n = 1'b1;
    tick(8'h00);

    // rising trigger on ramp, P=4
    do_arm(2'd1, 8'h80, 4'd4);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 20; i++) begin
      tick(8'(i * 16));
      if (i == 7) chk("t1_pre_trig", triggered, 0);
      if (i == 8) begin
        chk("t1_trig", triggered, 1);
        chk("t1_start", start_addr, 4);
      end
      if (i == 18) chk("t1_done_early", capture_done, 0);
      if (i == 19) begin
        chk("t1_done", capture_done, 1);
        chk("t1_busy_low", busy, 0);
      end
    end
    for (int k = 0; k < 16; k++) rd(k, 8'((k + 4) * 16));
    rd_end();

    // software trigger, P=0, first sample
    trig_in = 1'b0;
    do_arm(2'd0, 8'h00, 4'd0);
    chk("t2_trig_clr", triggered, 0);
    chk("t2_done_clr", capture_done, 0);
    chk("t2_busy", busy, 1);
    trig_in = 1'b1;
    tick(8'h5A);
    trig_in = 1'b0;
    chk("t2_trig", triggered, 1);
    chk("t2_start", start_addr, 0);
    for (int i = 1; i < 16; i++) tick(8'(8'h5A + i * 37));
    chk("t2_done", capture_done, 1);
    for (int k = 0; k < 16; k++) rd(k, 8'(8'h5A + k * 37));
    rd_end();

    // falling trigger, P=15 gives empty POST
    do_arm(2'd2, 8'h20, 4'd15);
    for (int i = 0; i < 50; i++) tick(8'h10);
    chk("t3_no_trig", triggered, 0);
    chk("t3_busy", busy, 1);
    tick(8'h30);
    chk("t3_no_trig_up", triggered, 0);
    tick(8'h10);
    chk("t3_trig", triggered, 1);
    chk("t3_done", capture_done, 1);
    chk("t3_busy_low", busy, 0);
    chk("t3_start", start_addr, 4);
    rd(0, 8'h10);
    rd(14, 8'h30);
    rd(15, 8'h10);
    rd_end();

    // abort during PRE
    do_arm(2'd3, 8'h00, 4'd4);
    tick(8'h01);
    tick(8'h02);
    chk("t4a_busy", busy, 1);
    abort = 1'b1;
    tick(8'h03);
    abort = 1'b0;
    chk("t4a_busy_low", busy, 0);
    chk("t4a_trig", triggered, 0);
    chk("t4a_done", capture_done, 0);
    tick(8'h04);
    tick(8'h05);
    chk("t4a_idle", busy, 0);

    // abort during WAIT_TRIG
    do_arm(2'd3, 8'h00, 4'd0);
    tick(8'h01);
    tick(8'h02);
    abort = 1'b1;
    tick(8'h03);
    abort = 1'b0;
    chk("t4c_busy_low", busy, 0);
    chk("t4c_trig", triggered, 0);

    // second arm while busy is ignored
    trig_in = 1'b0;
    do_arm(2'd0, 8'h00, 4'd2);
    tick(8'h11);
    tick(8'h22);
    tick(8'h33);
    chk("t4b_busy", busy, 1);
    chk("t4b_no_trig", triggered, 0);
    arm = 1'b1;
    pretrig_len = 4'd8;
    trig_mode = 2'd3;
    tick(8'h44);
    arm = 1'b0;
    trig_in = 1'b1;
    tick(8'h55);
    trig_in = 1'b0;
    chk("t4b_trig", triggered, 1);
    chk("t4b_start", start_addr, 2);
    for (int i = 0; i < 13; i++) tick(8'(8'h60 + i));
    chk("t4b_done", capture_done, 1);
    rd(0, 8'h33);
    rd(1, 8'h44);
    rd(2, 8'h55);
    rd_end();

    // abort together with arm in DONE
    arm = 1'b1;
    abort = 1'b1;
    tick(8'h00);
    arm = 1'b0;
    abort = 1'b0;
    chk("t4d_busy", busy, 0);
    chk("t4d_done", capture_done, 0);
    chk("t4d_trig", triggered, 0);
    tick(8'h00);
    chk("t4d_idle", busy, 0);

    // reset during POST
    trig_in = 1'b0;
    do_arm(2'd0, 8'h00, 4'd3);
    tick(8'h01);
    tick(8'h02);
    tick(8'h03);
    tick(8'h04);
    tick(8'h05);
    trig_in = 1'b1;
    tick(8'h99);
    trig_in = 1'b0;
    tick(8'h06);
    tick(8'h07);
    chk("t5_start_pre", start_addr, 2);
    chk("t5_busy_pre", busy, 1);
    reset_n = 1'b0;
    tick(8'h00);
    chk("t5_busy", busy, 0);
    chk("t5_trig", triggered, 0);
    chk("t5_done", capture_done, 0);
    chk("t5_start", start_addr, 0);
    chk("t5_rdata", read_data, 0);
    reset_n = 1'b1;
    tick(8'h00);

    // re-arm from DONE with a new P
    do_arm(2'd0, 8'h00, 4'd3);
    tick(8'hA0);
    tick(8'hA1);
    tick(8'hA2);
    trig_in = 1'b1;
    tick(8'hA3);
    trig_in = 1'b0;
    chk("t6_start_a", start_addr, 0);
    for (int i = 4; i < 16; i++) tick(8'(8'hA0 + i));
    chk("t6_done_a", capture_done, 1);
    do_arm(2'd0, 8'h00, 4'd6);
    chk("t6_done_clr", capture_done, 0);
    chk("t6_trig_clr", triggered, 0);
    chk("t6_busy", busy, 1);
    for (int i = 0; i < 8; i++) tick(8'(8'hB0 + i));
    trig_in = 1'b1;
    tick(8'hB8);
    trig_in = 1'b0;
    chk("t6_start_b", start_addr, 2);
    for (int i = 9; i < 18; i++) tick(8'(8'hB0 + i));
    chk("t6_done_b", capture_done, 1);
    rd(0, 8'hB2);
    rd(6, 8'hB8);
    rd(15, 8'hC1);
    rd_end();

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_capture_engine.md
# adc_capture_engine

Parametrised, triggered ADC capture engine: the next generation of the single-shot 4096-sample capture block. It records a fixed-length window of 2^ADDR_WIDTH samples around a trigger event, with a programmable pre-trigger length and software, rising-level or falling-level trigger modes. The block owns an inferred single-clock RAM and presents a read port indexed in record order, so downstream processor and debug logic never handles the ring-buffer wrap.

## Interface
- DATA_WIDTH, 8, width of one ADC sample (unsigned).
- ADDR_WIDTH, 12, buffer address width; record length DEPTH = 2^ADDR_WIDTH.
- adc_clock  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- adc_data  in  DATA_WIDTH  ADC sample, valid every adc_clock cycle.
- arm  in  1  start a capture (accepted only in IDLE or DONE).
- abort  in  1  cancel any capture; return to IDLE.
- trig_mode  in  2  0 = software (trig_in), 1 = rising crossing, 2 = falling crossing, 3 = reserved (never triggers).
- trig_in  in  1  software/external trigger, used in mode 0.
- threshold  in  DATA_WIDTH  level-trigger threshold.
- pretrig_len  in  ADDR_WIDTH  pre-trigger samples P, 0..DEPTH-1.
- busy  out  1  high in PRE, WAIT_TRIG, POST.
- triggered  out  1  high from the cycle after the trigger until next arm, abort or reset.
- capture_done  out  1  record complete; held until next arm, abort or reset.
- start_addr  out  ADDR_WIDTH  physical address of record sample 0.
- read_addr  in  ADDR_WIDTH  logical index into the record (0 = oldest sample).
- read_data  out  DATA_WIDTH  sample at the logical index, registered.

## Operation
- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- Reset: state IDLE; busy, triggered and capture_done are 0; start_addr, internal write pointer and read_data are 0. RAM contents are not cleared.
- arm in IDLE or DONE:
  - Latches trig_mode, threshold and pretrig_len. Later changes are ignored until the next arm.
  - Clears triggered and capture_done. Sets the write pointer to 0.
  - Next state is PRE if P > 0, otherwise WAIT_TRIG.
- arm in PRE, WAIT_TRIG or POST is ignored.
- PRE: writes adc_data every cycle and the pointer increments. After P writes the state moves to WAIT_TRIG. No trigger is evaluated in PRE.
- WAIT_TRIG: writes adc_data every cycle, the pointer wraps modulo DEPTH, and the trigger is evaluated on the sample being written.
  - Mode 0 trigger: trig_in = 1.
  - Mode 1 trigger: prev < threshold and adc_data >= threshold.
  - Mode 2 trigger: prev > threshold and adc_data <= threshold.
  - prev is the previous cycle's sample, held in a register. prev is invalid on the first WAIT_TRIG cycle when P = 0, so no level trigger can fire on that cycle.
  - All comparisons are unsigned.
- On trigger:
  - The current sample is the trigger sample, at physical address T.
  - start_addr <= (T - P) mod DEPTH.
  - Next state is POST with a remaining count of DEPTH - P - 1.
- POST: writes one sample per cycle. After the remaining count is exhausted the state moves to DONE. If DEPTH - P - 1 = 0, the block goes straight to DONE on the cycle after the trigger.
- DONE: no writes; capture_done = 1; the read port holds a valid record.
- abort:
  - Forces IDLE from any state and clears busy, triggered and capture_done.
  - abort wins over a simultaneous arm or trigger.
  - In IDLE or DONE, abort also clears capture_done.
- Read port:
  - Physical address = (start_addr + read_addr) mod DEPTH, ADDR_WIDTH-bit wrap.
  - Reads are always allowed. Contents are meaningful only when capture_done = 1.
- Pointer and count arithmetic is ADDR_WIDTH bits with natural wrap. There is no overflow flag: old samples are overwritten while waiting for a trigger, by design.

## Timing
- Edge k samples arm = 1: adc_data at edge k+1 is written to address 0.
- The trigger sample is written at edge t. Then:
  - triggered and start_addr are valid after edge t.
  - The last sample is written at edge t + DEPTH - P - 1.
  - capture_done = 1 and busy = 0 after that same edge.
- read_data latency is 1 cycle: read_addr at edge n gives read_data valid after edge n.
- busy rises after the arm edge and falls after the last-write edge or the abort edge.
- Reset asserted mid-capture: IDLE after that edge, with all outputs at their reset values.

## Test plan
- ADDR_WIDTH = 4, P = 4, mode 1, threshold 0x80, ramp 0x00,0x10,…:
  - Trigger is sample 0x80.
  - Read indices 0..15 return 0x40..0x70, then 0x80..0xF0, then 0x00..0x30 (ramp wrapped).
  - capture_done rises 11 cycles after the trigger edge.
- Mode 0, P = 0, trig_in held high on the first WAIT_TRIG cycle:
  - Trigger is the first sample, start_addr = 0.
  - Record equals 16 consecutive inputs; triggered is high one cycle after.
- Mode 2, threshold 0x20, constant 0x10 for 50 cycles then 0x30/0x10 toggle:
  - No trigger during the constant run.
  - Trigger fires on the first 0x30 -> 0x10 transition.
  - P = 15 makes POST length 0: DONE on the cycle after the trigger.
- abort asserted during PRE, during WAIT_TRIG, and together with arm in DONE:
  - IDLE next cycle; busy, triggered and capture_done are all 0.
  - A second arm during busy is ignored.
- reset_n low for 1 cycle during POST: all outputs go to 0 and the state goes to IDLE.
- Re-arm from DONE with new pretrig_len: flags clear, and the new P is honoured in start_addr.
